// File: rtl/fptd_pkg.sv
// Shared definitions for the RSC encoder: trellis state type, frame FSM states,
// BPSK mapping and the single-step trellis function.
package fptd_pkg;

    typedef logic [2:0] rsc_state_t;

    localparam int TAIL_LEN = 3;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } fsm_t;

    typedef struct packed {
        rsc_state_t next;
        logic       b1;
        logic       b2;
    } rsc_step_t;

    // Returns +mag for a 0 bit and -mag for a 1 bit; callers size the result.
    function automatic int bpsk_map(input logic b, input int mag);
        return b ? -mag : mag;
    endfunction

    // State bits are {s1,s2,s3}; in a tail step the input is forced so the feedback is 0.
    function automatic rsc_step_t rsc_step(input rsc_state_t s, input logic u, input logic tail);
        rsc_step_t r;
        logic      s1;
        logic      s2;
        logic      s3;
        logic      uu;
        logic      f;
        s1     = s[2];
        s2     = s[1];
        s3     = s[0];
        uu     = tail ? (s2 ^ s3) : u;
        f      = uu ^ s2 ^ s3;
        r.next = {f, s1, s2};
        r.b1   = uu;
        r.b2   = f ^ s1 ^ s3;
        return r;
    endfunction

endpackage

// File: rtl/rsc_trellis_step.sv
// Combinational single trellis step of the RSC constituent code, shared with
// the decoder-side reference models.
module rsc_trellis_step
    import fptd_pkg::*;
(
    input  logic [2:0] state,
    input  logic       u,
    input  logic       tail,
    output logic [2:0] next_state,
    output logic       b1,
    output logic       b2
);

    rsc_step_t step;

    always_comb begin
        step       = rsc_step(state, u, tail);
        next_state = step.next;
        b1         = step.b1;
        b2         = step.b2;
    end

endmodule

// File: rtl/rsc_frame_encoder.sv
// Serial RSC frame encoder: K data steps followed by three termination steps,
// with a single registered output slot under a valid/ready handshake.
module rsc_frame_encoder
    import fptd_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 5,
    parameter int K = 40,
    parameter int A = 7
) (
    input  logic                Clock,
    input  logic                nReset,
    input  logic                nClear,
    input  logic                Enable,
    input  logic                in_valid,
    input  logic                in_bit,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                b1,
    output logic                b2,
    output logic signed [M-1:0] ba1,
    output logic signed [N-1:0] ba2,
    output logic                out_first,
    output logic                out_tail,
    output logic                out_last
);

    localparam int DW = $clog2(K + 1);

    if (A < 1 || A > (2 ** (N - 1)) - 1 || A > (2 ** (M - 1)) - 1) begin : g_bad_magnitude
        $error("rsc_frame_encoder: BPSK magnitude A does not fit the soft output widths");
    end

    fsm_t                fsm_q, fsm_d;
    logic [DW-1:0]       data_cnt_q, data_cnt_d;
    logic [1:0]          tail_cnt_q, tail_cnt_d;
    rsc_state_t          trellis_q, trellis_d;
    logic                out_valid_q, out_valid_d;
    logic                b1_q, b1_d;
    logic                b2_q, b2_d;
    logic signed [M-1:0] ba1_q, ba1_d;
    logic signed [N-1:0] ba2_q, ba2_d;
    logic                first_q, first_d;
    logic                tail_q, tail_d;
    logic                last_q, last_d;

    logic       slot_free;
    logic       data_fire;
    logic       tail_fire;
    logic       in_tail;
    logic [2:0] step_next;
    logic       step_b1;
    logic       step_b2;
    logic [DW-1:0] data_cnt_inc;

    assign in_tail      = (fsm_q == TAIL);
    assign slot_free    = !out_valid_q || out_ready;
    assign in_ready     = nReset && Enable && nClear && !in_tail && slot_free;
    assign data_fire    = in_valid && in_ready;
    assign tail_fire    = in_tail && Enable && nClear && slot_free;
    assign data_cnt_inc = data_cnt_q + DW'(1);

    rsc_trellis_step u_step (
        .state      (trellis_q),
        .u          (in_bit),
        .tail       (in_tail),
        .next_state (step_next),
        .b1         (step_b1),
        .b2         (step_b2)
    );

    always_comb begin
        fsm_d       = fsm_q;
        data_cnt_d  = data_cnt_q;
        tail_cnt_d  = tail_cnt_q;
        trellis_d   = trellis_q;
        out_valid_d = out_valid_q;
        b1_d        = b1_q;
        b2_d        = b2_q;
        ba1_d       = ba1_q;
        ba2_d       = ba2_q;
        first_d     = first_q;
        tail_d      = tail_q;
        last_d      = last_q;

        if (!nClear) begin
            // Abort: the held symbol is discarded along with the frame context.
            fsm_d       = IDLE;
            data_cnt_d  = '0;
            tail_cnt_d  = '0;
            trellis_d   = '0;
            out_valid_d = 1'b0;
            b1_d        = 1'b0;
            b2_d        = 1'b0;
            ba1_d       = '0;
            ba2_d       = '0;
            first_d     = 1'b0;
            tail_d      = 1'b0;
            last_d      = 1'b0;
        end else if (data_fire || tail_fire) begin
            trellis_d   = step_next;
            out_valid_d = 1'b1;
            b1_d        = step_b1;
            b2_d        = step_b2;
            ba1_d       = M'(bpsk_map(step_b1, A));
            ba2_d       = N'(bpsk_map(step_b2, A));
            first_d     = data_fire && (fsm_q == IDLE);
            tail_d      = tail_fire;
            last_d      = tail_fire && (tail_cnt_q == 2'(TAIL_LEN - 1));

            if (data_fire) begin
                if (data_cnt_inc == DW'(K)) begin
                    fsm_d      = TAIL;
                    data_cnt_d = '0;
                    tail_cnt_d = '0;
                end else begin
                    fsm_d      = DATA;
                    data_cnt_d = data_cnt_inc;
                end
            end else if (tail_cnt_q == 2'(TAIL_LEN - 1)) begin
                fsm_d      = IDLE;
                tail_cnt_d = '0;
            end else begin
                tail_cnt_d = tail_cnt_q + 2'd1;
            end
        end else if (Enable && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            fsm_q       <= IDLE;
            data_cnt_q  <= '0;
            tail_cnt_q  <= '0;
            trellis_q   <= '0;
            out_valid_q <= 1'b0;
            b1_q        <= 1'b0;
            b2_q        <= 1'b0;
            ba1_q       <= '0;
            ba2_q       <= '0;
            first_q     <= 1'b0;
            tail_q      <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            data_cnt_q  <= data_cnt_d;
            tail_cnt_q  <= tail_cnt_d;
            trellis_q   <= trellis_d;
            out_valid_q <= out_valid_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            ba1_q       <= ba1_d;
            ba2_q       <= ba2_d;
            first_q     <= first_d;
            tail_q      <= tail_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign b1        = b1_q;
    assign b2        = b2_q;
    assign ba1       = ba1_q;
    assign ba2       = ba2_q;
    assign out_first = first_q;
    assign out_tail  = tail_q;
    assign out_last  = last_q;

endmodule
